// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between an issuing pipeline and muldiv_unit.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (output start_i, funct3_i, a_i, b_i, flush_i,
                  input  busy_o, done_o, result_o);
  modport slave  (input  start_i, funct3_i, a_i, b_i, flush_i,
                  output busy_o, done_o, result_o);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M unit: 32-cycle shift-add multiply and restoring divide
// on operand magnitudes, sign fixed up on the edge that enters DONE.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  muldiv_unit_if.slave  bus
);

  muldiv_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [XLEN-1:0]     result_q, result_d;
  muldiv_op_e          op_q, op_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;

  // ---------------- request decode ----------------
  muldiv_op_e      op_in;
  logic            a_sgn, b_sgn, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, special_res;

  assign op_in = muldiv_op_e'(bus.funct3_i);

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        a_sgn = bus.a_i[XLEN-1];
        b_sgn = bus.b_i[XLEN-1];
      end
      OP_MULHSU: a_sgn = bus.a_i[XLEN-1];
      default: ;
    endcase
    a_abs    = a_sgn ? (XLEN'(0) - bus.a_i) : bus.a_i;
    b_abs    = b_sgn ? (XLEN'(0) - bus.b_i) : bus.b_i;
    div_zero = (bus.b_i == '0);
    div_ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
               (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_i == '1);
    special  = bus.funct3_i[2] && (div_zero || div_ovf);
    // funct3[1] separates the remainder forms from the quotient forms
    if (div_zero) special_res = bus.funct3_i[1] ? bus.a_i : '1;
    else          special_res = bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // ---------------- one radix-2 step ----------------
  logic [XLEN:0]     mul_sum, div_tmp, div_diff;
  logic [2*XLEN-1:0] iter_nxt, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, fin_res;

  always_comb begin
    // acc = {partial_hi, multiplier_lo}: add at the top, shift right
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // acc = {remainder, dividend/quotient}: shift left, trial subtract
    div_tmp  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_tmp - {1'b0, opb_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) iter_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 iter_nxt = {div_tmp[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};
    end else begin
      iter_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod_fix = negq_q ? ((2*XLEN)'(0) - iter_nxt) : iter_nxt;
    q_fix    = negq_q ? (XLEN'(0) - iter_nxt[XLEN-1:0]) : iter_nxt[XLEN-1:0];
    r_fix    = negr_q ? (XLEN'(0) - iter_nxt[2*XLEN-1:XLEN]) : iter_nxt[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        fin_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fin_res = q_fix;
      default:                       fin_res = r_fix;
    endcase
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    opb_d    = opb_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    if (!bus.flush_i) begin
      case (state_q)
        S_IDLE: if (bus.start_i) begin
          op_d   = op_in;
          opb_d  = b_abs;
          acc_d  = {{XLEN{1'b0}}, a_abs};
          cnt_d  = '0;
          negq_d = a_sgn ^ b_sgn;
          negr_d = a_sgn;
          if (special) result_d = special_res;
        end
        S_CALC: begin
          acc_d = iter_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) result_d = fin_res;
        end
        default: ;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (bus.start_i) state_d = special ? S_DONE : S_CALC;
        S_CALC:  if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy_o   = (state_q != S_IDLE);
    bus.done_o   = (state_q == S_DONE);
    bus.result_o = result_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= OP_MUL;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

endmodule
